seq_divider: RTL and testbench

- Multi-cycle restoring divider; the inverse operation of the team's combinational 8-bit multipliers.
- Accepts WIDTH-bit dividend/divisor in unsigned or two's-complement signed mode; returns quotient and remainder.
- Start/busy/done handshake.
- Sits beside the multipliers in the arithmetic unit; one division in flight at a time.

---
 rtl/div_pkg.sv | 17 +
 rtl/div_step.sv | 21 ++
 rtl/seq_divider.sv | 137 +++++++++++++
 tb/tb_seq_divider.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SIGN = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam int DIV_WIDTH = 8;

    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract |divisor|.
module div_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0] rem_i,
    input  logic           dvd_msb_i,
    input  logic [WIDTH:0] dvs_i,
    output logic [WIDTH:0] rem_o,
    output logic           q_bit_o
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] trial;

    // rem_i < |divisor| <= 2^WIDTH, so shifted fits WIDTH+1 bits and the top bit is the borrow.
    assign shifted = {rem_i, dvd_msb_i};
    assign trial   = shifted - {1'b0, dvs_i};
    assign q_bit_o = ~trial[WIDTH+1];
    assign rem_o   = q_bit_o ? trial[WIDTH:0] : shifted[WIDTH:0];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider, unsigned or two's-complement, start/busy/done handshake.
// SEQ_DIVIDER_FAST_ZERO_EN: a zero divisor skips the CALC phase.
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = cnt_width(WIDTH);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] raw_q, raw_d;
    logic [WIDTH:0]   dvs_q, dvs_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic             q_neg_q, q_neg_d, r_neg_q, r_neg_d, dz_q, dz_d;
    logic [WIDTH-1:0] quo_q, quo_d, rmd_q, rmd_d;
    logic             dzo_q, dzo_d;

    logic [WIDTH:0]   dvs_ext, dvs_abs;
    logic [WIDTH:0]   step_rem;
    logic             step_q;

    assign dvs_ext = {signed_mode & divisor[WIDTH-1], divisor};
    assign dvs_abs = (signed_mode && divisor[WIDTH-1]) ? -dvs_ext : dvs_ext;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i     (rem_q),
        .dvd_msb_i (dvd_q[WIDTH-1]),
        .dvs_i     (dvs_q),
        .rem_o     (step_rem),
        .q_bit_o   (step_q)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        raw_d   = raw_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        dz_d    = dz_q;
        quo_d   = quo_q;
        rmd_d   = rmd_q;
        dzo_d   = dzo_q;
        case (state_q)
            IDLE: if (start) begin
                // Negating in WIDTH bits and reading unsigned yields 2^(WIDTH-1) for the most-negative value.
                dvd_d   = (signed_mode && dividend[WIDTH-1]) ? -dividend : dividend;
                raw_d   = dividend;
                dvs_d   = dvs_abs;
                q_neg_d = signed_mode & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                r_neg_d = signed_mode & dividend[WIDTH-1];
                dz_d    = (divisor == '0);
                rem_d   = '0;
                cnt_d   = CW'(WIDTH);
`ifdef SEQ_DIVIDER_FAST_ZERO_EN
                state_d = (divisor == '0) ? SIGN : CALC;
`else
                state_d = CALC;
`endif
            end
            CALC: begin
                rem_d = step_rem;
                dvd_d = {dvd_q[WIDTH-2:0], step_q};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = SIGN;
            end
            SIGN: begin
                if (dz_q) begin
                    quo_d = '1;
                    rmd_d = raw_q;
                    dzo_d = 1'b1;
                end else begin
                    quo_d = q_neg_q ? -dvd_q : dvd_q;
                    rmd_d = r_neg_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
                    dzo_d = 1'b0;
                end
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            raw_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            dz_q    <= 1'b0;
            quo_q   <= '0;
            rmd_q   <= '0;
            dzo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            raw_q   <= raw_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            dz_q    <= dz_d;
            quo_q   <= quo_d;
            rmd_q   <= rmd_d;
            dzo_q   <= dzo_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign quotient    = quo_q;
    assign remainder   = rmd_q;
    assign div_by_zero = dzo_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed cases plus randomized traffic against a behavioural model.
module tb_seq_divider;

    localparam int W = 8;
`ifdef SEQ_DIVIDER_FAST_ZERO_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst, start, signed_mode;
    logic [W-1:0] dividend, divisor;
    logic         busy, done, div_by_zero;
    logic [W-1:0] quotient, remainder;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    seq_divider #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode),
        .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
        .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Plain arithmetic reference: {quotient, remainder, div_by_zero}
    function automatic logic [2*W:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm);
        longint sa, sb, q, r;
        if (b == '0) return {{W{1'b1}}, a, 1'b1};
        if (sm) begin
            sa = $signed(a);
            sb = $signed(b);
        end else begin
            sa = a;
            sb = b;
        end
        q = sa / sb;
        r = sa % sb;
        return {q[W-1:0], r[W-1:0], 1'b0};
    endfunction

    // Transaction-level model: accept when idle, results appear lat edges later, idle one edge after that.
    logic         m_busy, m_done, m_dz;
    logic [W-1:0] m_q, m_r;
    logic [2*W:0] p_res;
    int           m_cnt, m_lat;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_q <= '0; m_r <= '0; m_dz <= 1'b0;
            m_cnt  <= 0;    m_lat  <= 0;
        end else if (!m_busy) begin
            if (start) begin
                p_res  <= ref_div(dividend, divisor, signed_mode);
                m_lat  <= (FAST && divisor == '0) ? 1 : W + 1;
                m_cnt  <= 0;
                m_busy <= 1'b1;
            end
        end else begin
            m_cnt <= m_cnt + 1;
            if (m_cnt + 1 == m_lat) begin
                m_done <= 1'b1;
                m_q    <= p_res[2*W:W+1];
                m_r    <= p_res[W:1];
                m_dz   <= p_res[0];
            end
            if (m_cnt + 1 == m_lat + 1) begin
                m_done <= 1'b0;
                m_busy <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc busy", busy, m_busy);
            chk("cyc done", done, m_done);
            chk("cyc quotient", quotient, m_q);
            chk("cyc remainder", remainder, m_r);
            chk("cyc div_by_zero", div_by_zero, m_dz);
        end
    end

    // Issue one division from idle; report edges to done and cycles busy.
    task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm,
                      output int lat, output int bcnt);
        @(negedge clk);
        dividend = a; divisor = b; signed_mode = sm; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0; bcnt = 0;
        while (!done && lat < 40) begin
            if (busy) bcnt++;
            @(negedge clk);
            lat++;
        end
        while (busy && bcnt < 40) begin
            bcnt++;
            @(negedge clk);
        end
    endtask

    task automatic op_chk(input string nm, input logic [W-1:0] a, input logic [W-1:0] b, input logic sm,
                          input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz);
        int lat, bcnt;
        op(a, b, sm, lat, bcnt);
        chk({nm, " q"}, quotient, eq);
        chk({nm, " r"}, remainder, er);
        chk({nm, " dz"}, div_by_zero, edz);
        chk({nm, " latency"}, lat, (FAST && b == '0) ? 1 : W + 1);
        chk({nm, " busy cycles"}, bcnt, (FAST && b == '0) ? 2 : W + 2);
    endtask

    int dcnt;

    initial begin
        rst = 1'b1; start = 1'b0; signed_mode = 1'b0; dividend = '0; divisor = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset q", quotient, 0);
        chk("reset r", remainder, 0);
        chk("reset dz", div_by_zero, 0);
        rst = 1'b0;

        op_chk("u 51/5",     8'h33, 8'h05, 1'b0, 8'd10, 8'd1,  1'b0);
        op_chk("u 205/16",   8'hCD, 8'h10, 1'b0, 8'd12, 8'd13, 1'b0);
        op_chk("s -51/16",   8'hCD, 8'h10, 1'b1, 8'hFD, 8'hFD, 1'b0);
        op_chk("s 16/-16",   8'h10, 8'hF0, 1'b1, 8'hFF, 8'h00, 1'b0);
        op_chk("s -128/-1",  8'h80, 8'hFF, 1'b1, 8'h80, 8'h00, 1'b0);
        op_chk("u 7/0",      8'h07, 8'h00, 1'b0, 8'hFF, 8'h07, 1'b1);
        op_chk("s 7/0",      8'h07, 8'h00, 1'b1, 8'hFF, 8'h07, 1'b1);
        op_chk("s -128/0",   8'h80, 8'h00, 1'b1, 8'hFF, 8'h80, 1'b1);

        // Second start on edge 3 of a running 51/5 must be dropped.
        @(negedge clk);
        dividend = 8'h33; divisor = 8'h05; signed_mode = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk); dividend = 8'hFF; divisor = 8'h01; start = 1'b1;
        @(negedge clk); start = 1'b0;
        dcnt = 0;
        repeat (W + 14) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        chk("ignored start done count", dcnt, 1);
        chk("ignored start q", quotient, 8'd10);
        chk("ignored start r", remainder, 8'd1);

        // Reset mid-CALC: outputs clear at once, aborted op never signals done.
        @(negedge clk);
        dividend = 8'h33; divisor = 8'h05; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort busy", busy, 0);
        chk("abort done", done, 0);
        chk("abort q", quotient, 0);
        chk("abort r", remainder, 0);
        chk("abort dz", div_by_zero, 0);
        @(negedge clk); rst = 1'b0;
        dcnt = 0;
        repeat (W + 6) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        chk("abort no done", dcnt, 0);
        op_chk("u 255/255", 8'hFF, 8'hFF, 1'b0, 8'd1, 8'd0, 1'b0);

        // Randomized traffic: starts and operand changes every cycle, including while busy.
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            start       = ($urandom_range(0, 2) == 0);
            signed_mode = $urandom_range(0, 1);
            case ($urandom_range(0, 9))
                0:       divisor = 8'h00;
                1:       divisor = 8'hFF;
                2:       divisor = 8'h80;
                default: divisor = W'($urandom);
            endcase
            dividend = ($urandom_range(0, 7) == 0) ? 8'h80 : W'($urandom);
            rst      = ($urandom_range(0, 299) == 0);
        end
        @(negedge clk);
        start = 1'b0; rst = 1'b0;
        repeat (W + 4) @(negedge clk);
        chk("drain idle", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
